// File: rtl/bm_output_led_sink.sv
// LED sink for one BondMachine output port. It acknowledges each published value, queues it
// in a small FIFO, and replays each value on the LEDs for HOLD_CYCLES cycles.
module bm_output_led_sink #(
    parameter int DATA_W      = 1,
    parameter int LED_W       = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 1000000
) (
    input  logic                        clk,
    input  logic                        reset_signal,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_valid,
    output logic                        in_received,
    output logic [LED_W-1:0]            led,
    output logic                        led_update,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  hold_count;
    logic [DATA_W-1:0] head;
    logic [LED_W-1:0]  head_led;
    logic              fifo_full, fifo_empty, push, pop, count_down;

    assign fifo_full  = (fifo_level == LVL_FULL);
    assign fifo_empty = (fifo_level == '0);
    // The acknowledge cycle is the producer's blank cycle, so it can never accept.
    assign push       = in_valid & ~fifo_full & ~in_received;
    assign head       = mem[rd_ptr];
    assign busy       = (state == HOLD);

    generate
        if (DATA_W >= LED_W) begin : g_trunc
            assign head_led = head[LED_W-1:0];
        end else begin : g_zext
            assign head_led = {{(LED_W-DATA_W){1'b0}}, head};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset_signal) begin
        if (reset_signal) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            in_received <= 1'b0;
        end else begin
            in_received <= push;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_signal) begin
        if (reset_signal) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A pop at the end of a hold reloads the counter directly, so queued values run back-to-back.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        count_down = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (hold_count == '0) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    count_down = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_signal) begin
        if (reset_signal) begin
            led        <= '0;
            led_update <= 1'b0;
            hold_count <= '0;
        end else begin
            led_update <= pop;
            if (pop) begin
                led        <= head_led;
                hold_count <= HOLD_LOAD;
            end else if (count_down) begin
                hold_count <= hold_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bm_output_led_sink.sv
// Randomized bench for bm_output_led_sink. It checks an 8-bit instance against a queue-based
// reference model and a 1-bit instance against a blink pattern.
module tb_bm_output_led_sink;
    localparam int HOLD  = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_signal;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_received;
    logic [7:0] led;
    logic       led_update;
    logic [2:0] fifo_level;
    logic       busy;

    logic [0:0] b_data;
    logic       b_valid, b_received, b_update, b_busy;
    logic [7:0] b_led;
    logic [2:0] b_level;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    logic [7:0] prod_q[$];
    int         prod_gap = 0;
    int         gap_cnt = 0;

    // Reference model: a queue of (value, write time) plus the start time of the current display.
    logic [7:0] mq_v[$];
    int         mq_t[$];
    logic       m_vin, m_recv, m_upd, m_busy, m_started;
    logic [7:0] m_din, m_led;
    int         m_level, m_start;

    int         d_recv_cnt, d_upd_cnt, d_busy_cnt, d_max_level, d_both2, d_stall;
    int         d_recv_t[$], d_upd_t[$];
    logic [7:0] d_led_seq[$];

    bm_output_led_sink #(.DATA_W(8), .LED_W(8), .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset_signal(reset_signal), .in_data(in_data), .in_valid(in_valid),
        .in_received(in_received), .led(led), .led_update(led_update),
        .fifo_level(fifo_level), .busy(busy)
    );

    bm_output_led_sink #(.DATA_W(1), .LED_W(8), .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut_blink (
        .clk(clk), .reset_signal(reset_signal), .in_data(b_data), .in_valid(b_valid),
        .in_received(b_received), .led(b_led), .led_update(b_update),
        .fifo_level(b_level), .busy(b_busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq_v.delete();
        mq_t.delete();
        m_vin = 1'b0; m_recv = 1'b0; m_upd = 1'b0; m_busy = 1'b0; m_started = 1'b0;
        m_din = 8'h00; m_led = 8'h00; m_level = 0; m_start = 0;
    endtask

    task automatic obs_reset();
        d_recv_cnt = 0; d_upd_cnt = 0; d_busy_cnt = 0; d_max_level = 0; d_both2 = 0; d_stall = 0;
        d_recv_t.delete(); d_upd_t.delete(); d_led_seq.delete();
    endtask

    // Advance one clock, update the model, record what the DUT did and let the producer react.
    task automatic step();
        logic acc;
        @(posedge clk);
        #1;
        cyc++;
        acc = m_vin && !m_recv && (mq_v.size() < DEPTH);
        m_upd = 1'b0;
        if (mq_v.size() > 0 && mq_t[0] < cyc && (!m_started || cyc >= m_start + HOLD)) begin
            m_led = mq_v.pop_front();
            mq_t.delete(0);
            m_upd = 1'b1;
            m_start = cyc;
            m_started = 1'b1;
        end
        if (acc) begin
            mq_v.push_back(m_din);
            mq_t.push_back(cyc);
        end
        m_recv = acc;
        m_level = mq_v.size();
        m_busy = m_started && (cyc < m_start + HOLD);

        if (in_received === 1'b1) begin d_recv_cnt++; d_recv_t.push_back(cyc); end
        if (led_update === 1'b1) begin d_upd_cnt++; d_upd_t.push_back(cyc); d_led_seq.push_back(led); end
        if (busy === 1'b1) d_busy_cnt++;
        if (int'(fifo_level) > d_max_level) d_max_level = int'(fifo_level);
        if (in_received === 1'b1 && led_update === 1'b1 && fifo_level == 3'd2) d_both2++;
        if (in_valid && in_received !== 1'b1 && fifo_level == 3'd4) d_stall++;

        if (in_received === 1'b1 && in_valid) begin
            if (prod_q.size() > 0) prod_q.delete(0);
            in_valid = 1'b0;
            gap_cnt = (prod_gap >= 0) ? prod_gap : int'($urandom_range(0, 2));
        end
        if (!in_valid && prod_q.size() > 0) begin
            if (gap_cnt > 0) begin
                gap_cnt--;
            end else begin
                in_data = prod_q[0];
                in_valid = 1'b1;
            end
        end
        m_vin = in_valid;
        m_din = in_data;
    endtask

    function automatic bit stream_done();
        return prod_q.size() == 0 && !in_valid && mq_v.size() == 0 && !m_busy;
    endfunction

    task automatic test_reset();
        reset_signal = 1'b1;
        in_valid = 1'b0; in_data = 8'h00; b_valid = 1'b0; b_data = 1'b0;
        prod_q.delete(); gap_cnt = 0;
        model_reset(); obs_reset();
        repeat (2) @(posedge clk);
        #1;
        compared++; if (in_received !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_received: got %b expected 0", in_received); end
        compared++; if (led !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_led: got %h expected 00", led); end
        compared++; if (led_update !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_update: got %b expected 0", led_update); end
        compared++; if (fifo_level !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        compared++; if (b_led !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_blink_led: got %h expected 00", b_led); end
        @(negedge clk);
        reset_signal = 1'b0;
    endtask

    task automatic test_single();
        int n;
        prod_gap = 0; gap_cnt = 0; obs_reset();
        prod_q.push_back(8'hA5);
        n = 0;
        while (n < 100 && !stream_done()) begin
            step();
            compared++; if (in_received !== m_recv) begin mismatched++; $display("[TB] FAIL single_recv cyc %0d: got %b expected %b", cyc, in_received, m_recv); end
            compared++; if (led_update !== m_upd) begin mismatched++; $display("[TB] FAIL single_update cyc %0d: got %b expected %b", cyc, led_update, m_upd); end
            compared++; if (led !== m_led) begin mismatched++; $display("[TB] FAIL single_led cyc %0d: got %h expected %h", cyc, led, m_led); end
            compared++; if (fifo_level !== 3'(m_level)) begin mismatched++; $display("[TB] FAIL single_level cyc %0d: got %0d expected %0d", cyc, fifo_level, m_level); end
            compared++; if (busy !== m_busy) begin mismatched++; $display("[TB] FAIL single_busy cyc %0d: got %b expected %b", cyc, busy, m_busy); end
            n++;
        end
        compared++; if (n >= 100) begin mismatched++; $display("[TB] FAIL single_timeout: got %0d cycles expected < 100", n); end
        repeat (3) step();
        compared++; if (d_recv_cnt != 1) begin mismatched++; $display("[TB] FAIL single_recv_pulses: got %0d expected 1", d_recv_cnt); end
        compared++; if (d_upd_cnt != 1) begin mismatched++; $display("[TB] FAIL single_update_pulses: got %0d expected 1", d_upd_cnt); end
        compared++; if (d_busy_cnt != HOLD) begin mismatched++; $display("[TB] FAIL single_busy_cycles: got %0d expected %0d", d_busy_cnt, HOLD); end
        compared++; if (led !== 8'hA5) begin mismatched++; $display("[TB] FAIL single_led_kept: got %h expected a5", led); end
        // led_update is seen one edge after in_received, which is two cycles after the accept cycle.
        if (d_recv_t.size() == 1 && d_upd_t.size() == 1) begin
            compared++; if (d_upd_t[0] - d_recv_t[0] != 1) begin mismatched++; $display("[TB] FAIL single_latency: got %0d expected 1", d_upd_t[0] - d_recv_t[0]); end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [7:0] vals[$];
        prod_gap = 0; gap_cnt = 0; obs_reset();
        vals = '{8'h01, 8'h02, 8'h03};
        foreach (vals[i]) prod_q.push_back(vals[i]);
        n = 0;
        while (n < 100 && !stream_done()) begin
            step();
            compared++; if (in_received !== m_recv) begin mismatched++; $display("[TB] FAIL b2b_recv cyc %0d: got %b expected %b", cyc, in_received, m_recv); end
            compared++; if (led_update !== m_upd) begin mismatched++; $display("[TB] FAIL b2b_update cyc %0d: got %b expected %b", cyc, led_update, m_upd); end
            compared++; if (led !== m_led) begin mismatched++; $display("[TB] FAIL b2b_led cyc %0d: got %h expected %h", cyc, led, m_led); end
            compared++; if (fifo_level !== 3'(m_level)) begin mismatched++; $display("[TB] FAIL b2b_level cyc %0d: got %0d expected %0d", cyc, fifo_level, m_level); end
            compared++; if (busy !== m_busy) begin mismatched++; $display("[TB] FAIL b2b_busy cyc %0d: got %b expected %b", cyc, busy, m_busy); end
            n++;
        end
        compared++; if (n >= 100) begin mismatched++; $display("[TB] FAIL b2b_timeout: got %0d cycles expected < 100", n); end
        compared++; if (d_led_seq.size() != 3) begin mismatched++; $display("[TB] FAIL b2b_count: got %0d expected 3", d_led_seq.size()); end
        for (int i = 0; i < 3 && i < d_led_seq.size(); i++) begin
            compared++; if (d_led_seq[i] !== vals[i]) begin mismatched++; $display("[TB] FAIL b2b_order[%0d]: got %h expected %h", i, d_led_seq[i], vals[i]); end
        end
        for (int i = 1; i < d_upd_t.size(); i++) begin
            compared++; if (d_upd_t[i] - d_upd_t[i-1] != HOLD) begin mismatched++; $display("[TB] FAIL b2b_hold[%0d]: got %0d expected %0d", i, d_upd_t[i] - d_upd_t[i-1], HOLD); end
        end
        for (int i = 1; i < d_recv_t.size(); i++) begin
            compared++; if (d_recv_t[i] - d_recv_t[i-1] != 2) begin mismatched++; $display("[TB] FAIL b2b_accept_gap[%0d]: got %0d expected 2", i, d_recv_t[i] - d_recv_t[i-1]); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [7:0] vals[$];
        prod_gap = 0; gap_cnt = 0; obs_reset();
        for (int i = 0; i < 10; i++) vals.push_back(8'($urandom));
        foreach (vals[i]) prod_q.push_back(vals[i]);
        n = 0;
        while (n < 200 && !stream_done()) begin
            step();
            compared++; if (in_received !== m_recv) begin mismatched++; $display("[TB] FAIL bp_recv cyc %0d: got %b expected %b", cyc, in_received, m_recv); end
            compared++; if (led_update !== m_upd) begin mismatched++; $display("[TB] FAIL bp_update cyc %0d: got %b expected %b", cyc, led_update, m_upd); end
            compared++; if (led !== m_led) begin mismatched++; $display("[TB] FAIL bp_led cyc %0d: got %h expected %h", cyc, led, m_led); end
            compared++; if (fifo_level !== 3'(m_level)) begin mismatched++; $display("[TB] FAIL bp_level cyc %0d: got %0d expected %0d", cyc, fifo_level, m_level); end
            compared++; if (busy !== m_busy) begin mismatched++; $display("[TB] FAIL bp_busy cyc %0d: got %b expected %b", cyc, busy, m_busy); end
            n++;
        end
        compared++; if (n >= 200) begin mismatched++; $display("[TB] FAIL bp_timeout: got %0d cycles expected < 200", n); end
        compared++; if (d_max_level != DEPTH) begin mismatched++; $display("[TB] FAIL bp_max_level: got %0d expected %0d", d_max_level, DEPTH); end
        compared++; if (d_stall == 0) begin mismatched++; $display("[TB] FAIL bp_stall: got %0d stalled cycles expected > 0", d_stall); end
        compared++; if (d_led_seq.size() != vals.size()) begin mismatched++; $display("[TB] FAIL bp_count: got %0d expected %0d", d_led_seq.size(), vals.size()); end
        for (int i = 0; i < vals.size() && i < d_led_seq.size(); i++) begin
            compared++; if (d_led_seq[i] !== vals[i]) begin mismatched++; $display("[TB] FAIL bp_order[%0d]: got %h expected %h", i, d_led_seq[i], vals[i]); end
        end
    endtask

    // With a 3-cycle accept spacing, a push and a pop eventually share an edge at level 2.
    task automatic test_wrap();
        int n;
        logic [7:0] vals[$];
        prod_gap = 2; gap_cnt = 0; obs_reset();
        for (int i = 0; i < 12; i++) vals.push_back(8'($urandom));
        foreach (vals[i]) prod_q.push_back(vals[i]);
        n = 0;
        while (n < 300 && !stream_done()) begin
            step();
            compared++; if (in_received !== m_recv) begin mismatched++; $display("[TB] FAIL wrap_recv cyc %0d: got %b expected %b", cyc, in_received, m_recv); end
            compared++; if (led_update !== m_upd) begin mismatched++; $display("[TB] FAIL wrap_update cyc %0d: got %b expected %b", cyc, led_update, m_upd); end
            compared++; if (led !== m_led) begin mismatched++; $display("[TB] FAIL wrap_led cyc %0d: got %h expected %h", cyc, led, m_led); end
            compared++; if (fifo_level !== 3'(m_level)) begin mismatched++; $display("[TB] FAIL wrap_level cyc %0d: got %0d expected %0d", cyc, fifo_level, m_level); end
            compared++; if (busy !== m_busy) begin mismatched++; $display("[TB] FAIL wrap_busy cyc %0d: got %b expected %b", cyc, busy, m_busy); end
            n++;
        end
        compared++; if (n >= 300) begin mismatched++; $display("[TB] FAIL wrap_timeout: got %0d cycles expected < 300", n); end
        compared++; if (d_both2 == 0) begin mismatched++; $display("[TB] FAIL wrap_push_pop_at_2: got %0d edges expected > 0", d_both2); end
        compared++; if (d_led_seq.size() != vals.size()) begin mismatched++; $display("[TB] FAIL wrap_count: got %0d expected %0d", d_led_seq.size(), vals.size()); end
        for (int i = 0; i < vals.size() && i < d_led_seq.size(); i++) begin
            compared++; if (d_led_seq[i] !== vals[i]) begin mismatched++; $display("[TB] FAIL wrap_order[%0d]: got %h expected %h", i, d_led_seq[i], vals[i]); end
        end
    endtask

    task automatic test_random();
        int n;
        logic [7:0] vals[$];
        prod_gap = -1; gap_cnt = 0; obs_reset();
        for (int i = 0; i < 20; i++) vals.push_back(8'($urandom));
        foreach (vals[i]) prod_q.push_back(vals[i]);
        n = 0;
        while (n < 500 && !stream_done()) begin
            step();
            compared++; if (in_received !== m_recv) begin mismatched++; $display("[TB] FAIL rand_recv cyc %0d: got %b expected %b", cyc, in_received, m_recv); end
            compared++; if (led_update !== m_upd) begin mismatched++; $display("[TB] FAIL rand_update cyc %0d: got %b expected %b", cyc, led_update, m_upd); end
            compared++; if (led !== m_led) begin mismatched++; $display("[TB] FAIL rand_led cyc %0d: got %h expected %h", cyc, led, m_led); end
            compared++; if (fifo_level !== 3'(m_level)) begin mismatched++; $display("[TB] FAIL rand_level cyc %0d: got %0d expected %0d", cyc, fifo_level, m_level); end
            compared++; if (busy !== m_busy) begin mismatched++; $display("[TB] FAIL rand_busy cyc %0d: got %b expected %b", cyc, busy, m_busy); end
            n++;
        end
        compared++; if (n >= 500) begin mismatched++; $display("[TB] FAIL rand_timeout: got %0d cycles expected < 500", n); end
        compared++; if (d_led_seq.size() != vals.size()) begin mismatched++; $display("[TB] FAIL rand_count: got %0d expected %0d", d_led_seq.size(), vals.size()); end
        for (int i = 0; i < vals.size() && i < d_led_seq.size(); i++) begin
            compared++; if (d_led_seq[i] !== vals[i]) begin mismatched++; $display("[TB] FAIL rand_order[%0d]: got %h expected %h", i, d_led_seq[i], vals[i]); end
        end
    endtask

    task automatic test_reset_mid_hold();
        int n;
        prod_gap = 0; gap_cnt = 0; obs_reset();
        prod_q.push_back(8'h11); prod_q.push_back(8'h22); prod_q.push_back(8'h33);
        n = 0;
        while (n < 40 && !(fifo_level == 3'd2 && busy === 1'b1)) begin
            step();
            n++;
        end
        compared++; if (n >= 40) begin mismatched++; $display("[TB] FAIL midreset_setup: got %0d cycles expected < 40", n); end
        #2;
        reset_signal = 1'b1;
        #1;
        compared++; if (led !== 8'h00) begin mismatched++; $display("[TB] FAIL midreset_led: got %h expected 00", led); end
        compared++; if (led_update !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_update: got %b expected 0", led_update); end
        compared++; if (fifo_level !== 3'd0) begin mismatched++; $display("[TB] FAIL midreset_level: got %0d expected 0", fifo_level); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
        compared++; if (in_received !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_received: got %b expected 0", in_received); end
        prod_q.delete(); in_valid = 1'b0; gap_cnt = 0;
        model_reset(); obs_reset();
        @(negedge clk);
        reset_signal = 1'b0;
        prod_q.push_back(8'h3C);
        n = 0;
        while (n < 100 && !stream_done()) begin
            step();
            compared++; if (led_update !== m_upd) begin mismatched++; $display("[TB] FAIL midreset_after_update cyc %0d: got %b expected %b", cyc, led_update, m_upd); end
            compared++; if (led !== m_led) begin mismatched++; $display("[TB] FAIL midreset_after_led cyc %0d: got %h expected %h", cyc, led, m_led); end
            compared++; if (fifo_level !== 3'(m_level)) begin mismatched++; $display("[TB] FAIL midreset_after_level cyc %0d: got %0d expected %0d", cyc, fifo_level, m_level); end
            compared++; if (busy !== m_busy) begin mismatched++; $display("[TB] FAIL midreset_after_busy cyc %0d: got %b expected %b", cyc, busy, m_busy); end
            n++;
        end
        compared++; if (n >= 100) begin mismatched++; $display("[TB] FAIL midreset_timeout: got %0d cycles expected < 100", n); end
        compared++; if (d_upd_cnt != 1) begin mismatched++; $display("[TB] FAIL midreset_updates: got %0d expected 1", d_upd_cnt); end
        compared++; if (led !== 8'h3C) begin mismatched++; $display("[TB] FAIL midreset_final_led: got %h expected 3c", led); end
    endtask

    task automatic test_blink();
        int idx;
        logic [7:0] seen[$];
        idx = 0;
        b_valid = 1'b0;
        for (int n = 0; n < 200 && seen.size() < 6; n++) begin
            @(posedge clk);
            #1;
            if (b_update === 1'b1) seen.push_back(b_led);
            compared++; if (b_led[7:1] !== 7'd0) begin mismatched++; $display("[TB] FAIL blink_upper_bits: got %h expected 00", b_led[7:1]); end
            if (b_received === 1'b1 && b_valid) begin
                idx++;
                b_valid = 1'b0;
            end
            if (!b_valid && idx < 6) begin
                b_data = idx[0];
                b_valid = 1'b1;
            end
        end
        compared++; if (seen.size() != 6) begin mismatched++; $display("[TB] FAIL blink_count: got %0d expected 6", seen.size()); end
        for (int i = 0; i < seen.size(); i++) begin
            compared++; if (seen[i] !== 8'(i % 2)) begin mismatched++; $display("[TB] FAIL blink_value[%0d]: got %h expected %h", i, seen[i], 8'(i % 2)); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_random();
        test_reset_mid_hold();
        test_blink();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
